load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Initiator side of the data-memory port: accepts one load/store request from the execute/memory stage and drives `mem_read`/`mem_write`/`mem_address`/`mem_write_data`.
- Consumes the memory's combinational `read_data`.
- Adds byte/halfword loads (sign/zero extend) and sub-word stores via read-modify-write on the word-wide memory.
- Detects misaligned, reserved-size and out-of-range accesses.

Parameters:
- MEM_WORDS, 256, number of 32-bit words behind the port; word index = addr[31:2].

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req  in  1  request strobe, sampled only when busy=0
- req_store  in  1  1=store, 0=load
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- req_signed  in  1  loads only: 1 sign-extend, 0 zero-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified for sub-word
- busy  out  1  state != IDLE
- done  out  1  one-cycle completion pulse
- fault  out  1  valid with done; access aborted
- load_data  out  32  valid while done=1 and fault=0, for loads only
- mem_read  out  1  to data memory
- mem_write  out  1  to data memory
- mem_address  out  32  word-aligned {addr[31:2],2'b00}
- mem_write_data  out  32  word to write
- mem_read_data  in  32  combinational read data from memory

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high. On reset: state=IDLE, busy=0, done=0, fault=0, load_data=0, mem_read=0, mem_write=0, mem_address=0, mem_write_data=0.
- Memory controls are decoded from the registered state only. Reset mid-access therefore drops mem_read/mem_write immediately; no partial write follows.
- States: IDLE, RD, WR, DONE.
- Request capture: in IDLE with req=1, latch all req_* fields at the posedge, then evaluate.
  - Fault when any of: req_size=11; size=01 and addr[0]=1; size=10 and addr[1:0]!=0; addr[31:2] >= MEM_WORDS.
  - On fault: go to DONE with fault=1. No memory cycle is issued at any point.
- Load: IDLE -> RD -> DONE.
  - In RD: mem_read=1. At the posedge, extract the lane from mem_read_data, extend it, and register it into load_data.
  - done rises 2 cycles after the accepting edge.
- Word store: IDLE -> WR -> DONE. In WR: mem_write=1 for exactly one cycle, mem_write_data=req_wdata.
- Sub-word store: IDLE -> RD -> WR -> DONE.
  - RD captures the old word.
  - WR writes the old word with only the addressed byte/half replaced by req_wdata[7:0]/[15:0].
- Lane mapping (default, big-endian):
  - Byte offset 0 = bits[31:24], offset 3 = bits[7:0].
  - Half offset 0 = bits[31:16], offset 2 = bits[15:0].
- DONE: done=1 for one cycle, then IDLE. A req during RD/WR/DONE is ignored and not queued; the next acceptance is possible in the cycle after DONE.
- load_data holds its last value until the next load completes. fault clears when leaving DONE.
- mem_address and mem_write_data are 0 whenever mem_read=0 and mem_write=0.
- Store requests never alter load_data.

Optional Feature:
- Macro LSU_LITTLE_ENDIAN_EN.
- Defined: little-endian lanes, i.e. byte offset 0 = bits[7:0], offset 3 = bits[31:24]; half offset 0 = bits[15:0], offset 2 = bits[31:16].
- Undefined: big-endian mapping as above.
- Fault rules, timing and everything else are identical in both builds.

Test Plan:
1. Preload word 0x20 = 0x80F01234 (big-endian build).
   - lb signed @0x20 -> load_data 0xFFFFFF80.
   - lbu @0x21 -> 0x000000F0.
   - lh @0x22 -> 0x00001234.
   - lhu @0x20 -> 0x000080F0.
   - Each load: done exactly 2 cycles after the accepting edge; mem_read high for exactly 1 cycle.
2. sb @0x21 data 0x000000AB on word 0x80F01234 -> one mem_read cycle, then one mem_write cycle with 0x80AB1234; memory word becomes 0x80AB1234; done on the 3rd cycle.
3. sw @0x24 data 0xDEADBEEF -> single mem_write cycle, no mem_read; memory[9] = 0xDEADBEEF; done on the 2nd cycle.
4. Faults: lh @0x21, lw @0x22, size=11, and lw @0x400 with MEM_WORDS=256 -> each gives done=1 with fault=1 one cycle after acceptance; mem_read and mem_write never asserted.
5. Reset during WR of an sh -> mem_write falls without waiting for a clock edge; target word unchanged; busy=0. A subsequent lw @0x20 returns the original word.
6. req held high continuously -> exactly one access per IDLE visit, with no accepts while busy. Repeat the item 1 loads in a LSU_LITTLE_ENDIAN_EN build: lb signed @0x20 -> 0x00000034.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: drives a word-wide data memory port with byte/half/word loads and
// read-modify-write sub-word stores. Define LSU_LITTLE_ENDIAN_EN for little-endian lanes.
module load_store_unit #(
    parameter int MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        req_store,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic [31:0] load_data,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

`ifdef LSU_LITTLE_ENDIAN_EN
    localparam bit LITTLE = 1'b1;
`else
    localparam bit LITTLE = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t      state_q;
    logic        store_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [31:0] addr_q;
    logic [31:0] wr_word_q;
    logic [31:0] load_data_q;
    logic        fault_q;

    logic        req_fault;
    logic [4:0]  shift;
    logic [31:0] rd_shifted;
    logic [31:0] lane_mask;
    logic [31:0] load_data_d;
    logic [31:0] wr_word_d;

    // Bit position of the addressed lane's LSB within the memory word.
    function automatic logic [4:0] lane_shift(input logic [1:0] size, input logic [1:0] off);
        logic [4:0] sh;
        if (LITTLE)
            sh = {off, 3'b000};
        else if (size == 2'b00)
            sh = {2'd3 - off, 3'b000};
        else if (size == 2'b01)
            sh = {2'd2 - off, 3'b000};
        else
            sh = 5'd0;
        return sh;
    endfunction

    always_comb begin
        req_fault = (req_size == 2'b11)
                 || (req_size == 2'b01 && req_addr[0])
                 || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
                 || ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS));

        shift      = lane_shift(size_q, addr_q[1:0]);
        rd_shifted = mem_read_data >> shift;
        case (size_q)
            2'b00:   load_data_d = {{24{signed_q & rd_shifted[7]}}, rd_shifted[7:0]};
            2'b01:   load_data_d = {{16{signed_q & rd_shifted[15]}}, rd_shifted[15:0]};
            default: load_data_d = rd_shifted;
        endcase

        // wr_word_q still holds the right-justified store data while in RD.
        lane_mask = ((size_q == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << shift;
        wr_word_d = (mem_read_data & ~lane_mask) | ((wr_word_q << shift) & lane_mask);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            store_q     <= 1'b0;
            size_q      <= 2'b00;
            signed_q    <= 1'b0;
            addr_q      <= '0;
            wr_word_q   <= '0;
            load_data_q <= '0;
            fault_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (req) begin
                    store_q   <= req_store;
                    size_q    <= req_size;
                    signed_q  <= req_signed;
                    addr_q    <= req_addr;
                    wr_word_q <= req_wdata;
                    if (req_fault) begin
                        fault_q <= 1'b1;
                        state_q <= DONE;
                    end else if (req_store && req_size == 2'b10) begin
                        state_q <= WR;
                    end else begin
                        state_q <= RD;
                    end
                end
                RD: begin
                    if (store_q) begin
                        wr_word_q <= wr_word_d;
                        state_q   <= WR;
                    end else begin
                        load_data_q <= load_data_d;
                        state_q     <= DONE;
                    end
                end
                WR:   state_q <= DONE;
                DONE: begin
                    fault_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // NOTE: memory strobes decode straight from state_q, so an async reset drops them
    // immediately and no write can complete after reset is asserted.
    assign busy           = (state_q != IDLE);
    assign done           = (state_q == DONE);
    assign fault          = fault_q;
    assign load_data      = load_data_q;
    assign mem_read       = (state_q == RD);
    assign mem_write      = (state_q == WR);
    assign mem_address    = (mem_read || mem_write) ? {addr_q[31:2], 2'b00} : 32'd0;
    assign mem_write_data = mem_write ? wr_word_q : 32'd0;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed plan steps plus randomized accesses
// checked against a byte-addressed reference memory model.
module tb_load_store_unit;

    localparam int MEM_WORDS = 256;
`ifdef LSU_LITTLE_ENDIAN_EN
    localparam bit LE = 1'b1;
`else
    localparam bit LE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        req_store = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        busy, done, fault, mem_read, mem_write;
    logic [31:0] load_data, mem_address, mem_write_data, mem_read_data;

    logic [31:0] mem     [MEM_WORDS];
    logic [31:0] ref_mem [MEM_WORDS];
    logic [31:0] exp_ld;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk(clk), .reset(reset), .req(req), .req_store(req_store), .req_size(req_size),
        .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .busy(busy), .done(done), .fault(fault), .load_data(load_data),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    // Data memory: combinational read, synchronous write; seeded from the model at t=1.
    assign mem_read_data = mem[mem_address[9:2]];
    initial begin
        #1;
        for (int i = 0; i < MEM_WORDS; i++) mem[i] = ref_mem[i];
        forever begin
            @(posedge clk);
            if (mem_write) mem[mem_address[9:2]] <= mem_write_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---- reference model: memory viewed as individually addressed bytes ----
    function automatic logic [7:0] rbyte(input logic [31:0] a);
        int o  = int'(a % 4);
        int sh = LE ? 8 * o : 8 * (3 - o);
        return 8'((ref_mem[int'(a >> 2)] >> sh) & 32'hFF);
    endfunction

    function automatic void wbyte(input logic [31:0] a, input logic [7:0] b);
        int o  = int'(a % 4);
        int sh = LE ? 8 * o : 8 * (3 - o);
        logic [31:0] w = ref_mem[int'(a >> 2)];
        w = (w & ~(32'hFF << sh)) | (32'(b) << sh);
        ref_mem[int'(a >> 2)] = w;
    endfunction

    function automatic bit model_fault(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0)
            || (a / 4 >= MEM_WORDS);
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] sz, input bit sg, input logic [31:0] a);
        logic [31:0] v;
        logic [7:0]  b0, b1, b2, b3;
        b0 = rbyte(a); b1 = (sz != 2'd0) ? rbyte(a + 1) : 8'h00;
        b2 = (sz == 2'd2) ? rbyte(a + 2) : 8'h00; b3 = (sz == 2'd2) ? rbyte(a + 3) : 8'h00;
        if (sz == 2'd0) begin
            v = {24'd0, b0};
            if (sg && b0 >= 8'h80) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = LE ? {16'd0, b1, b0} : {16'd0, b0, b1};
            if (sg && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end else begin
            v = LE ? {b3, b2, b1, b0} : {b0, b1, b2, b3};
        end
        return v;
    endfunction

    function automatic void model_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        if (sz == 2'd0) begin
            wbyte(a, d[7:0]);
        end else if (sz == 2'd1) begin
            wbyte(a,     LE ? d[7:0]  : d[15:8]);
            wbyte(a + 1, LE ? d[15:8] : d[7:0]);
        end else begin
            for (int i = 0; i < 4; i++) wbyte(a + i, LE ? d[8*i +: 8] : d[31-8*i -: 8]);
        end
    endfunction

    // One complete access: drive, follow it to done, compare timing, strobes and results.
    task automatic txn(input bit st, input logic [1:0] sz, input bit sg,
                       input logic [31:0] a, input logic [31:0] d);
        bit f, seen;
        int lat, nrd, nwr, exp_rd, exp_wr;
        f      = model_fault(sz, a);
        exp_rd = (!f && (!st || sz != 2'd2)) ? 1 : 0;
        exp_wr = (!f && st) ? 1 : 0;
        if (!f && !st) exp_ld = model_load(sz, sg, a);
        @(negedge clk);
        req = 1'b1; req_store = st; req_size = sz; req_signed = sg; req_addr = a; req_wdata = d;
        @(posedge clk);
        seen = 1'b0; lat = 0; nrd = 0; nwr = 0;
        for (int k = 1; k <= 8 && !seen; k++) begin
            @(negedge clk);
            req = 1'b0;
            check("busy", 32'(busy), 32'd1);
            if (mem_read)  nrd++;
            if (mem_write) nwr++;
            if (mem_read || mem_write) begin
                check("mem_address", mem_address, {a[31:2], 2'b00});
            end else begin
                check("idle_address", mem_address, 32'd0);
                check("idle_wdata", mem_write_data, 32'd0);
            end
            if (done) begin seen = 1'b1; lat = k; end
        end
        check("done_latency", 32'(lat), 32'(1 + exp_rd + exp_wr));
        check("fault", 32'(fault), 32'(f));
        check("mem_read_cycles", 32'(nrd), 32'(exp_rd));
        check("mem_write_cycles", 32'(nwr), 32'(exp_wr));
        check("load_data", load_data, exp_ld);
        if (!f && st) begin
            model_store(sz, a, d);
            check("mem_word", mem[int'(a >> 2)], ref_mem[int'(a >> 2)]);
        end
    endtask

    initial begin
        int nrd, nd;
        bit st, sg;
        logic [1:0] sz;
        logic [31:0] a;
        for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = $urandom;
        ref_mem[8] = 32'h80F0_1234;
        exp_ld = 32'd0;

        // Reset state
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_load_data", load_data, 32'd0);
        check("rst_mem_read", 32'(mem_read), 32'd0);
        check("rst_mem_write", 32'(mem_write), 32'd0);
        check("rst_mem_address", mem_address, 32'd0);
        check("rst_mem_wdata", mem_write_data, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Sub-word loads of 0x80F01234
        txn(1'b0, 2'd0, 1'b1, 32'h20, 32'd0);
        check("lb_0x20", load_data, LE ? 32'h0000_0034 : 32'hFFFF_FF80);
        txn(1'b0, 2'd0, 1'b0, 32'h21, 32'd0);
        check("lbu_0x21", load_data, LE ? 32'h0000_0012 : 32'h0000_00F0);
        txn(1'b0, 2'd1, 1'b1, 32'h22, 32'd0);
        check("lh_0x22", load_data, LE ? 32'hFFFF_80F0 : 32'h0000_1234);
        txn(1'b0, 2'd1, 1'b0, 32'h20, 32'd0);
        check("lhu_0x20", load_data, LE ? 32'h0000_1234 : 32'h0000_80F0);

        // Byte store read-modify-write, then word store
        txn(1'b1, 2'd0, 1'b0, 32'h21, 32'h0000_00AB);
        check("sb_word", mem[8], LE ? 32'h80F0_AB34 : 32'h80AB_1234);
        txn(1'b1, 2'd2, 1'b0, 32'h24, 32'hDEAD_BEEF);
        check("sw_word", mem[9], 32'hDEAD_BEEF);

        // Faulting requests
        txn(1'b0, 2'd1, 1'b1, 32'h21, 32'd0);
        txn(1'b0, 2'd2, 1'b0, 32'h22, 32'd0);
        txn(1'b0, 2'd3, 1'b0, 32'h20, 32'd0);
        txn(1'b0, 2'd2, 1'b0, 32'h400, 32'd0);
        txn(1'b1, 2'd2, 1'b0, 32'h400, 32'h1111_2222);

        // Reset while a halfword store is in its write cycle
        @(negedge clk);
        req = 1'b1; req_store = 1'b1; req_size = 2'd1; req_signed = 1'b0;
        req_addr = 32'h20; req_wdata = 32'h0000_5555;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        check("rmw_read_phase", 32'(mem_read), 32'd1);
        @(negedge clk);
        check("rmw_write_phase", 32'(mem_write), 32'd1);
        reset = 1'b1;
        #1;
        check("reset_drops_write", 32'(mem_write), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_address", mem_address, 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        exp_ld = 32'd0;
        check("reset_word_kept", mem[8], ref_mem[8]);
        check("reset_load_data", load_data, 32'd0);
        txn(1'b0, 2'd2, 1'b0, 32'h20, 32'd0);
        check("lw_after_reset", load_data, ref_mem[8]);

        // req held high: one load per IDLE visit (RD, DONE, IDLE repeating)
        @(negedge clk);
        req = 1'b1; req_store = 1'b0; req_size = 2'd2; req_addr = 32'h24;
        @(posedge clk);
        nrd = 0; nd = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (mem_read) nrd++;
            if (done) nd++;
            if (k == 12) req = 1'b0;
        end
        check("held_req_reads", 32'(nrd), 32'd4);
        check("held_req_dones", 32'(nd), 32'd4);
        exp_ld = model_load(2'd2, 1'b0, 32'h24);
        check("held_req_data", load_data, exp_ld);
        @(negedge clk);
        check("held_req_idle", 32'(busy), 32'd0);

        // Randomized accesses
        for (int n = 0; n < 80; n++) begin
            st = 1'($urandom_range(0, 1));
            sg = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            a  = ($urandom_range(0, 9) == 0) ? (32'h400 + $urandom_range(0, 4095))
                                             : 32'($urandom_range(0, 4 * MEM_WORDS - 1));
            txn(st, sz, sg, a, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
